// File: rtl/wiegand_rx_if.sv
// Frame delivery bundle between the Wiegand receiver and its local-bus consumer.
// Latency: none, wires only.
// Backpressure: frame_valid/frame_ready; the master holds a frame until the slave takes it.
interface wiegand_rx_if #(
    parameter int NBITS = 26
);
    logic [NBITS-1:0] frame_data;
    logic [7:0]       frame_bits;
    logic             frame_err;
    logic             frame_valid;
    logic             frame_ready;

    modport master (
        output frame_data,
        output frame_bits,
        output frame_err,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_data,
        input  frame_bits,
        input  frame_err,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/wiegand_rx.sv
// Wiegand D0/D1 front end: synchronise, deglitch, assemble, check and hold one frame.
// Latency: bit accepted 2+GLITCH_CYC cycles after a line falls; frame_valid TIMEOUT_CYC cycles after the last bit.
// Backpressure: one-entry holding register; a frame completing while it is full and not being read is dropped and flags ovf.
module wiegand_rx #(
    parameter int NBITS       = 26,
    parameter int TIMEOUT_CYC = 5000,
    parameter int GLITCH_CYC  = 3,
    parameter int PARITY_EN   = 1
) (
    input  logic         clk,
    input  logic         HRESET,
    input  logic [1:0]   wil,
    wiegand_rx_if.master fif,
    output logic         ovf,
    input  logic         ovf_clr,
    output logic         IRQ
);
    localparam int          H        = (NBITS - 2) / 2;
    localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]  GMAX     = 4'(GLITCH_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, RECV} state_t;

    logic [1:0]       sync1, sync2, filt;
    logic [1:0][3:0]  cnt;
    logic [1:0]       ev;
    logic             ev_any, coll_now, both_low, bit_in;
    state_t           state, state_nxt;
    logic             done;
    logic [NBITS-1:0] shreg;
    logic [7:0]       bitcnt;
    logic [TW-1:0]    tmo;
    logic             coll_r;
    logic             len_err, par_err, err_now;
    logic             load, drop;

    // Two-flop synchroniser followed by a low-run filter on each line.
    always_ff @(posedge clk) begin
        if (HRESET) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            filt  <= 2'b11;
            cnt   <= '0;
        end else begin
            sync1 <= wil;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i]) begin
                    cnt[i]  <= 4'd0;
                    filt[i] <= 1'b1;
                end else begin
                    if (cnt[i] != GMAX) cnt[i] <= cnt[i] + 4'd1;
                    if (cnt[i] == GMAX) filt[i] <= 1'b0;
                end
            end
        end
    end

    // Bit strobes fire on the sample that completes the low run, so the FSM
    // captures the bit on the same edge that the filtered line falls.
    always_comb begin
        ev = '0;
        for (int i = 0; i < 2; i++) begin
            ev[i] = ~sync2[i] & filt[i] & (cnt[i] == GMAX);
        end
        ev_any   = |ev;
        both_low = ~filt[0] & ~filt[1];
        coll_now = (&ev) | (ev[0] & ~filt[1]) | (ev[1] & ~filt[0]);
        bit_in   = ev[1] & ~coll_now;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (HRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; a bit event on the timeout cycle keeps the frame open.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: if (ev_any) state_nxt = RECV;
            RECV: begin
                if (!ev_any && tmo == TMO_LAST) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame assembly: shift register, saturating bit count, idle timer, collision flag.
    always_ff @(posedge clk) begin
        if (HRESET) begin
            shreg  <= '0;
            bitcnt <= 8'd0;
            tmo    <= '0;
            coll_r <= 1'b0;
        end else if (ev_any) begin
            tmo <= '0;
            if (state == IDLE) begin
                shreg  <= {{(NBITS-1){1'b0}}, bit_in};
                bitcnt <= 8'd1;
                coll_r <= coll_now;
            end else begin
                shreg  <= {shreg[NBITS-2:0], bit_in};
                bitcnt <= (bitcnt == 8'hFF) ? bitcnt : bitcnt + 8'd1;
                coll_r <= coll_r | coll_now | both_low;
            end
        end else if (state == RECV) begin
            coll_r <= coll_r | both_low;
            tmo    <= done ? '0 : tmo + TW'(1);
        end
    end

    // Leading bit gives even parity over the upper half, trailing bit odd parity over the lower half.
    always_comb begin
        len_err = (bitcnt != 8'(NBITS));
        par_err = (PARITY_EN != 0) && !len_err &&
                  ((^shreg[NBITS-1:NBITS-1-H]) || !(^shreg[H:0]));
        err_now = len_err | par_err | coll_r;
        load    = done & (~fif.frame_valid | fif.frame_ready);
        drop    = done & fif.frame_valid & ~fif.frame_ready;
    end

    // Holding register and sticky overflow; a drop beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (HRESET) begin
            fif.frame_data  <= '0;
            fif.frame_bits  <= 8'd0;
            fif.frame_err   <= 1'b0;
            fif.frame_valid <= 1'b0;
            ovf             <= 1'b0;
        end else begin
            if (load) begin
                fif.frame_data  <= shreg;
                fif.frame_bits  <= bitcnt;
                fif.frame_err   <= err_now;
                fif.frame_valid <= 1'b1;
            end else if (fif.frame_valid && fif.frame_ready) begin
                fif.frame_valid <= 1'b0;
            end
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    assign IRQ = ~fif.frame_valid;
endmodule

// File: tb/tb_wiegand_rx.sv
// Self-checking bench for wiegand_rx: directed scenarios plus randomised frames against a bit-list model.
// Latency: bench-side expectations derive frame arrival from the last line fall.
// Backpressure: the bench plays the consumer and drives frame_ready.
module tb_wiegand_rx;
    localparam int NB  = 26;
    localparam int TMO = 200;
    localparam int GC  = 3;
    localparam int PW  = 10;
    localparam int GAP = 40;
    localparam int H   = (NB - 2) / 2;

    logic       clk = 1'b0;
    logic       HRESET = 1'b1;
    logic [1:0] wil = 2'b11;
    logic       ovf, IRQ;
    logic       ovf_clr = 1'b0;

    wiegand_rx_if #(.NBITS(NB)) fif();

    wiegand_rx #(
        .NBITS(NB), .TIMEOUT_CYC(TMO), .GLITCH_CYC(GC), .PARITY_EN(1)
    ) dut (
        .clk(clk), .HRESET(HRESET), .wil(wil), .fif(fif),
        .ovf(ovf), .ovf_clr(ovf_clr), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int last_fall = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // b: 0 = D0 pulse, 1 = D1 pulse, 2 = both lines together.
    task automatic send_bit(input int b, input int wid, input int gap, input bit glitch);
        last_fall = cyc;
        if (b == 2)      wil = 2'b00;
        else if (b == 1) wil = 2'b01;
        else             wil = 2'b10;
        tick(wid);
        wil = 2'b11;
        if (glitch) begin
            tick(gap / 2 - 1);
            wil[1] = 1'b0;
            tick(2);
            wil[1] = 1'b1;
            tick(gap - gap / 2 - 1);
        end else begin
            tick(gap);
        end
    endtask

    // Sends v[len-1] first; one bit can be a collision, one gap can be stretched to exactly TMO fall-to-fall.
    task automatic send_frame(input logic [63:0] v, input int len, input int coll_idx,
                              input int long_idx, input bit glitch, input int wid);
        int b;
        for (int i = len - 1; i >= 0; i--) begin
            b = (i == coll_idx) ? 2 : int'(v[i]);
            send_bit(b, wid, (i == long_idx) ? TMO - wid : GAP + PW - wid, glitch);
        end
    endtask

    function automatic logic [63:0] mk_frame(input logic [23:0] p);
        logic ep, op;
        ep = ($countones(p[23:12]) % 2) != 0;
        op = ($countones(p[11:0]) % 2) == 0;
        return {38'd0, ep, p, op};
    endfunction

    // Expected register content: the last NB bits received, collision bit as 0, zero above.
    function automatic logic [63:0] exp_data(input logic [63:0] v, input int len, input int coll_idx);
        logic [63:0] d;
        d = v;
        if (coll_idx >= 0) d[coll_idx] = 1'b0;
        for (int i = 0; i < 64; i++) if (i >= NB || i >= len) d[i] = 1'b0;
        return d;
    endfunction

    function automatic logic exp_err(input logic [63:0] d, input int len, input bit coll);
        int up, lo;
        if (len != NB || coll) return 1'b1;
        up = 0;
        lo = 0;
        for (int i = NB - 1 - H; i <= NB - 1; i++) up += int'(d[i]);
        for (int i = 0; i <= H; i++) lo += int'(d[i]);
        return ((up % 2) != 0) || ((lo % 2) != 1);
    endfunction

    task automatic wait_frame(input string tag, input logic [63:0] ed, input int eb,
                              input logic ee, input bit timed);
        int exp_cyc, n;
        exp_cyc = last_fall + 2 + GC + TMO;
        n = 0;
        while (!fif.frame_valid && n < TMO + 500) begin
            tick(1);
            n++;
        end
        chk({tag, "_valid"}, 64'(fif.frame_valid), 64'd1);
        if (timed) chk({tag, "_time"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_data"}, 64'(fif.frame_data), ed);
        chk({tag, "_bits"}, 64'(fif.frame_bits), 64'(eb));
        chk({tag, "_err"},  64'(fif.frame_err), 64'(ee));
        chk({tag, "_irq"},  64'(IRQ), 64'd0);
    endtask

    task automatic pop(input string tag);
        fif.frame_ready = 1'b1;
        tick(1);
        fif.frame_ready = 1'b0;
        chk({tag, "_pop_valid"}, 64'(fif.frame_valid), 64'd0);
        chk({tag, "_pop_irq"},   64'(IRQ), 64'd1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_data"},  64'(fif.frame_data), 64'd0);
        chk({tag, "_bits"},  64'(fif.frame_bits), 64'd0);
        chk({tag, "_err"},   64'(fif.frame_err), 64'd0);
        chk({tag, "_valid"}, 64'(fif.frame_valid), 64'd0);
        chk({tag, "_ovf"},   64'(ovf), 64'd0);
        chk({tag, "_irq"},   64'(IRQ), 64'd1);
    endtask

    // Stimulus and checking.
    initial begin
        logic [63:0] good, fa, fb, fc, v;
        int          exp_cyc, len, fl;
        bit          gl;

        fif.frame_ready = 1'b0;
        good = 64'h2A5_F0F3;
        tick(3);
        check_reset_state("rst");
        HRESET = 1'b0;
        tick(5);

        // Reference frame with correct parity.
        send_frame(good, NB, -1, -1, 1'b0, PW);
        wait_frame("good", good, NB, 1'b0, 1'b1);
        pop("good");

        // Short burst: length error.
        send_frame(good >> 1, 25, -1, -1, 1'b0, PW);
        wait_frame("short", exp_data(good >> 1, 25, -1), 25, 1'b1, 1'b1);
        pop("short");

        // Trailing parity bit flipped.
        send_frame(good ^ 64'd1, NB, -1, -1, 1'b0, PW);
        wait_frame("par", good ^ 64'd1, NB, 1'b1, 1'b1);
        pop("par");

        // Two-cycle glitches on D1 between every bit are ignored.
        send_frame(good, NB, -1, -1, 1'b1, PW);
        wait_frame("glitch", good, NB, 1'b0, 1'b1);
        pop("glitch");

        // Pulses exactly GLITCH_CYC cycles wide are accepted.
        send_frame(good, NB, -1, -1, 1'b0, GC);
        wait_frame("minpw", good, NB, 1'b0, 1'b1);
        pop("minpw");

        // Collision on one bit: counted, shifted as 0, flagged.
        send_frame(good, NB, 7, -1, 1'b0, PW);
        wait_frame("coll", exp_data(good, NB, 7), NB, 1'b1, 1'b1);
        pop("coll");

        // Bit landing exactly on the last timeout cycle keeps the frame open.
        send_frame(good, NB, -1, 13, 1'b0, PW);
        wait_frame("tmoedge", good, NB, 1'b0, 1'b1);
        pop("tmoedge");

        // Overflow: second frame dropped while the first is held.
        fa = mk_frame(24'h13_579B);
        fb = mk_frame(24'hEC_A864);
        fc = mk_frame(24'h5A_C3E1);
        send_frame(fa, NB, -1, -1, 1'b0, PW);
        wait_frame("fa", fa, NB, 1'b0, 1'b1);
        send_frame(fb, NB, -1, -1, 1'b0, PW);
        exp_cyc = last_fall + 2 + GC + TMO;
        while (cyc < exp_cyc - 1) tick(1);
        chk("ovf_before", 64'(ovf), 64'd0);
        tick(1);
        chk("ovf_set", 64'(ovf), 64'd1);
        chk("ovf_held_data", 64'(fif.frame_data), fa);
        chk("ovf_held_valid", 64'(fif.frame_valid), 64'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 64'(ovf), 64'd0);

        // Third frame completes on the same edge the held frame is read.
        send_frame(fc, NB, -1, -1, 1'b0, PW);
        exp_cyc = last_fall + 2 + GC + TMO;
        while (cyc < exp_cyc - 1) tick(1);
        fif.frame_ready = 1'b1;
        tick(1);
        fif.frame_ready = 1'b0;
        chk("swap_valid", 64'(fif.frame_valid), 64'd1);
        chk("swap_data", 64'(fif.frame_data), fc);
        chk("swap_ovf", 64'(ovf), 64'd0);

        // Reset in the middle of a frame while one is held.
        send_frame(good >> 13, 13, -1, -1, 1'b0, PW);
        HRESET = 1'b1;
        tick(1);
        HRESET = 1'b0;
        check_reset_state("midrst");
        tick(TMO + 50);
        chk("midrst_noframe", 64'(fif.frame_valid), 64'd0);
        send_frame(good, NB, -1, -1, 1'b0, PW);
        wait_frame("postrst", good, NB, 1'b0, 1'b1);
        pop("postrst");

        // Randomised frames against the model.
        for (int r = 0; r < 6; r++) begin
            len = ($urandom_range(0, 1) == 1) ? NB : int'($urandom_range(24, 27));
            if (len == NB) begin
                v = mk_frame(24'($urandom));
                if ($urandom_range(0, 2) == 0) begin
                    fl = int'($urandom_range(0, NB - 1));
                    v[fl] = ~v[fl];
                end
            end else begin
                v = {$urandom, $urandom};
            end
            gl = 1'($urandom_range(0, 1));
            send_frame(v, len, -1, -1, gl, PW);
            wait_frame($sformatf("rnd%0d", r), exp_data(v, len, -1), len,
                       exp_err(exp_data(v, len, -1), len, 1'b0), 1'b1);
            pop($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
